// File: rtl/ide_bus_ctrl.sv
// ide_bus_ctrl: turns 68000 bus cycles in the autoconfigured IDE window into
// timed ATA PIO cycles (CS/IOR/IOW) or boot-ROM reads, and returns dtack.
// The optional IORDY strobe extension is compiled in when IDE_IORDY_EN is
// defined. Without it, IORDY is ignored and each strobe lasts exactly
// STROBE_CYC cycles.
module ide_bus_ctrl #(
  parameter int SETUP_CYC     = 1,
  parameter int STROBE_CYC    = 3,
  parameter int HOLD_CYC      = 1,
  parameter int ROM_CYC       = 2,
  parameter int IORDY_TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [16:1] ADDR,
  input  logic        AS_n,
  input  logic        UDS_n,
  input  logic        LDS_n,
  input  logic        RW,
  input  logic        ide_access,
  input  logic        IORDY,
  output logic        IDE_CS0_n,
  output logic        IDE_CS1_n,
  output logic        IDE_IOR_n,
  output logic        IDE_IOW_n,
  output logic [2:0]  IDE_A,
  output logic        ROM_CE_n,
  output logic        BUF_OE_n,
  output logic        BUF_DIR,
  output logic        dtack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROM,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_ACK
  } state_t;

  // Phase counters count down to zero. A programmed length of 0 behaves as 1.
  function automatic logic [3:0] phase_load(input logic [3:0] n);
    return (n == 4'd0) ? 4'd0 : (n - 4'd1);
  endfunction

  localparam logic [3:0] SETUP_LD  = phase_load(4'(SETUP_CYC));
  localparam logic [3:0] STROBE_LD = phase_load(4'(STROBE_CYC));
  localparam logic [3:0] HOLD_LD   = phase_load(4'(HOLD_CYC));
  localparam logic [3:0] ROM_LD    = phase_load(4'(ROM_CYC));

  state_t     state;
  logic [3:0] cnt;
  logic       aborted;
  logic       start_c;
  logic       strobe_wait;

  // Only ADDR[16], ADDR[12] and ADDR[11:9] take part in the decode.
  logic unused_addr;
  assign unused_addr = ^{ADDR[15:13], ADDR[8:1]};

  assign start_c = ide_access && !AS_n && (!UDS_n || !LDS_n);

`ifdef IDE_IORDY_EN
  localparam int TW = (IORDY_TIMEOUT < 1) ? 1 : $clog2(IORDY_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_V = TW'(IORDY_TIMEOUT);

  logic [TW-1:0] ext_cnt;

  // Keep the strobe asserted while the drive holds IORDY low, up to the timeout.
  assign strobe_wait = !IORDY && (ext_cnt < TMO_V);

  // Extra strobe cycles consumed in the current STROBE phase.
  always_ff @(posedge CLK) begin
    if (RESET || state != S_STROBE)
      ext_cnt <= '0;
    else if (cnt == 4'd0 && strobe_wait && !AS_n)
      ext_cnt <= ext_cnt + TW'(1);
  end
`else
  localparam int unused_timeout = IORDY_TIMEOUT;
  logic unused_iordy;
  assign unused_iordy = IORDY;
  assign strobe_wait  = 1'b0;
`endif

  // Bus-cycle sequencer; every output is a register updated here.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      aborted   <= 1'b0;
      IDE_CS0_n <= 1'b1;
      IDE_CS1_n <= 1'b1;
      IDE_IOR_n <= 1'b1;
      IDE_IOW_n <= 1'b1;
      IDE_A     <= 3'd0;
      ROM_CE_n  <= 1'b1;
      BUF_OE_n  <= 1'b1;
      BUF_DIR   <= 1'b0;
      dtack     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_c) begin
            BUF_DIR  <= RW;
            BUF_OE_n <= 1'b0;
            aborted  <= 1'b0;
            if (ADDR[16]) begin
              IDE_A     <= ADDR[11:9];
              IDE_CS0_n <= ADDR[12];
              IDE_CS1_n <= !ADDR[12];
              cnt       <= SETUP_LD;
              state     <= S_SETUP;
            end else begin
              // ROM writes only acknowledge; the ROM is never enabled.
              ROM_CE_n <= !RW;
              cnt      <= RW ? ROM_LD : 4'd0;
              state    <= S_ROM;
            end
          end
        end

        S_ROM: begin
          if (AS_n) begin
            ROM_CE_n <= 1'b1;
            aborted  <= 1'b1;
            cnt      <= 4'd0;
            state    <= S_HOLD;
          end else if (cnt == 4'd0) begin
            ROM_CE_n <= 1'b1;
            dtack    <= 1'b1;
            state    <= S_ACK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        S_SETUP: begin
          if (AS_n) begin
            aborted <= 1'b1;
            cnt     <= 4'd0;
            state   <= S_HOLD;
          end else if (cnt == 4'd0) begin
            IDE_IOR_n <= !BUF_DIR;
            IDE_IOW_n <= BUF_DIR;
            cnt       <= STROBE_LD;
            state     <= S_STROBE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        S_STROBE: begin
          if (AS_n) begin
            IDE_IOR_n <= 1'b1;
            IDE_IOW_n <= 1'b1;
            aborted   <= 1'b1;
            cnt       <= 4'd0;
            state     <= S_HOLD;
          end else if (cnt == 4'd0) begin
            if (!strobe_wait) begin
              IDE_IOR_n <= 1'b1;
              IDE_IOW_n <= 1'b1;
              cnt       <= HOLD_LD;
              state     <= S_HOLD;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        S_HOLD: begin
          if (AS_n && !aborted) begin
            // Late abort: one more HOLD cycle with CS held, then back to IDLE.
            aborted <= 1'b1;
            cnt     <= 4'd0;
          end else if (cnt == 4'd0) begin
            IDE_CS0_n <= 1'b1;
            IDE_CS1_n <= 1'b1;
            if (aborted) begin
              BUF_OE_n <= 1'b1;
              aborted  <= 1'b0;
              state    <= S_IDLE;
            end else begin
              dtack <= 1'b1;
              state <= S_ACK;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        S_ACK: begin
          if (AS_n) begin
            dtack    <= 1'b0;
            BUF_OE_n <= 1'b1;
            state    <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
